// File: rtl/tft_8080_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_8080_pkg
// Purpose  : Command codes, TE status bytes and responder state record
// Revision : 1.0
// ============================================================================
package tft_8080_pkg;

    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_SWRESET    = 8'h01;
    localparam logic [7:0] CMD_RDID       = 8'h04;
    localparam logic [7:0] CMD_RDTE       = 8'h0E;
    localparam logic [7:0] CMD_CASET      = 8'h2A;
    localparam logic [7:0] CMD_PASET      = 8'h2B;
    localparam logic [7:0] CMD_RAMWR      = 8'h2C;
    localparam logic [7:0] CMD_TEOFF      = 8'h34;
    localparam logic [7:0] CMD_TEON       = 8'h35;

    localparam logic [7:0] TE_STATUS_HIGH = 8'h80;
    localparam logic [7:0] TE_STATUS_LOW  = 8'h00;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  route;
        logic [2:0]  param_cnt;
        logic [1:0]  pix_cnt;
        logic [7:0]  red;
        logic [7:0]  green;
        logic [1:0]  rd_idx;
        logic [15:0] col_start;
        logic [15:0] col_end;
        logic [15:0] page_start;
        logic [15:0] page_end;
        logic [15:0] x;
        logic [15:0] y;
        logic        frame_start;
        logic        te_en;
        logic        te;
        logic        axis_valid;
        logic [23:0] axis_data;
        logic        axis_last;
        logic        axis_user;
        logic        overflow;
        logic [7:0]  rdata;
        logic        oe;
    } resp_state_t;

    function automatic resp_state_t state_reset(input logic [15:0] col_end_def,
                                                input logic [15:0] page_end_def);
        resp_state_t s;
        s          = '0;
        s.col_end  = col_end_def;
        s.page_end = page_end_def;
        return s;
    endfunction

    // An inverted window collapses to a single row/column at its start.
    function automatic logic [15:0] win_end(input logic [15:0] start_v,
                                            input logic [15:0] end_v);
        return (end_v < start_v) ? start_v : end_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tft_8080_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : tft_8080_bus_sync
// Purpose  : 2-FF synchronizers for the 8080 bus pins plus wr/rd edge detect
// Revision : 1.0
// ============================================================================
module tft_8080_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cs_n,
    input  logic       i_rs,
    input  logic       i_wr_n,
    input  logic       i_rd_n,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    output logic       o_write_strobe,
    output logic       o_read_strobe,
    output logic       o_read_active,
    output logic       o_rs,
    output logic       o_reset_n,
    output logic [7:0] o_data
);

    logic [1:0] cs_q;
    logic [1:0] rs_q;
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [1:0] rstn_q;
    logic       wr_prev_q;
    logic       rd_prev_q;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q      <= 2'b11;
            rs_q      <= 2'b00;
            wr_q      <= 2'b11;
            rd_q      <= 2'b11;
            rstn_q    <= 2'b00;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            data_q    <= 8'h00;
        end else begin
            cs_q      <= {cs_q[0], i_cs_n};
            rs_q      <= {rs_q[0], i_rs};
            wr_q      <= {wr_q[0], i_wr_n};
            rd_q      <= {rd_q[0], i_rd_n};
            rstn_q    <= {rstn_q[0], i_reset_n};
            wr_prev_q <= wr_q[1];
            rd_prev_q <= rd_q[1];
            data_q    <= i_data;
        end
    end

    // A read that starts while wr_n is also low is swallowed by the write.
    assign o_write_strobe = wr_q[1] & ~wr_prev_q & ~cs_q[1];
    assign o_read_strobe  = ~rd_q[1] & rd_prev_q & ~cs_q[1] & wr_q[1];
    assign o_read_active  = ~rd_q[1] & ~cs_q[1];
    assign o_rs           = rs_q[1];
    assign o_reset_n      = rstn_q[1];
    assign o_data         = data_q;

endmodule
`default_nettype wire

// File: rtl/tft_8080_responder.sv
`default_nettype none
// ============================================================================
// Module   : tft_8080_responder
// Purpose  : Panel-side 8080 bus responder: commands, reads, TE, pixel stream
// Revision : 1.0
// ============================================================================
module tft_8080_responder
    import tft_8080_pkg::*;
#(
    parameter int         TE_PERIOD        = 800,
    parameter int         TE_HIGH          = 400,
    parameter logic [7:0] ID_BYTE1         = 8'h01,
    parameter logic [7:0] ID_BYTE2         = 8'h93,
    parameter logic [7:0] ID_BYTE3         = 8'h41,
    parameter int         COL_END_DEFAULT  = 239,
    parameter int         PAGE_END_DEFAULT = 319
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_reset_n,
    input  logic        i_cs_n,
    input  logic        i_rs,
    input  logic        i_wr_n,
    input  logic        i_rd_n,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_data_oe,
    output logic        o_tearing_effect,
    output logic        o_axis_valid,
    input  logic        i_axis_ready,
    output logic [23:0] o_axis_data,
    output logic        o_axis_last,
    output logic        o_axis_user,
    output logic [7:0]  o_cmd,
    output logic        o_te_enable,
    output logic        o_overflow
);

    localparam int TE_W = (TE_PERIOD > 1) ? $clog2(TE_PERIOD) : 1;

    logic        w_wr;
    logic        w_rd;
    logic        w_rd_active;
    logic        w_rs;
    logic        w_rstn;
    logic [7:0]  w_data;
    logic        w_rst;
    logic        w_swreset;
    logic        w_pix_ok;
    logic [15:0] w_col_end;
    logic [15:0] w_page_end;

    resp_state_t      s_q;
    resp_state_t      s_d;
    logic [TE_W-1:0]  te_cnt_q;

    tft_8080_bus_sync u_bus_sync (
        .clk            (clk),
        .rst            (rst),
        .i_cs_n         (i_cs_n),
        .i_rs           (i_rs),
        .i_wr_n         (i_wr_n),
        .i_rd_n         (i_rd_n),
        .i_reset_n      (i_reset_n),
        .i_data         (i_data),
        .o_write_strobe (w_wr),
        .o_read_strobe  (w_rd),
        .o_read_active  (w_rd_active),
        .o_rs           (w_rs),
        .o_reset_n      (w_rstn),
        .o_data         (w_data)
    );

    assign w_rst      = rst | ~w_rstn;
    assign w_swreset  = w_wr & ~w_rs & (w_data == CMD_SWRESET);
    assign w_pix_ok   = ~(s_q.axis_valid & ~i_axis_ready);
    assign w_col_end  = win_end(s_q.col_start, s_q.col_end);
    assign w_page_end = win_end(s_q.page_start, s_q.page_end);

    always_comb begin
        s_d    = s_q;
        s_d.te = s_q.te_en && (te_cnt_q < TE_W'(TE_HIGH));
        if (s_q.axis_valid && i_axis_ready) s_d.axis_valid = 1'b0;
        if (!w_rd_active)                   s_d.oe         = 1'b0;

        if (w_wr && !w_rs) begin
            s_d.cmd       = w_data;
            // NOP only flushes counters; an ongoing memory write keeps its routing.
            if (w_data != CMD_NOP) s_d.route = w_data;
            s_d.param_cnt = '0;
            s_d.pix_cnt   = '0;
            s_d.rd_idx    = '0;
            case (w_data)
                CMD_TEOFF: s_d.te_en = 1'b0;
                CMD_TEON:  s_d.te_en = 1'b1;
                CMD_RAMWR: begin
                    s_d.x           = s_q.col_start;
                    s_d.y           = s_q.page_start;
                    s_d.frame_start = 1'b1;
                end
                default: ;
            endcase
        end else if (w_wr) begin
            if (s_q.param_cnt != 3'd4) s_d.param_cnt = s_q.param_cnt + 3'd1;
            case (s_q.route)
                CMD_CASET: begin
                    case (s_q.param_cnt)
                        3'd0:    s_d.col_start[15:8] = w_data;
                        3'd1:    s_d.col_start[7:0]  = w_data;
                        3'd2:    s_d.col_end[15:8]   = w_data;
                        3'd3:    s_d.col_end[7:0]    = w_data;
                        default: ;
                    endcase
                end
                CMD_PASET: begin
                    case (s_q.param_cnt)
                        3'd0:    s_d.page_start[15:8] = w_data;
                        3'd1:    s_d.page_start[7:0]  = w_data;
                        3'd2:    s_d.page_end[15:8]   = w_data;
                        3'd3:    s_d.page_end[7:0]    = w_data;
                        default: ;
                    endcase
                end
                CMD_RAMWR: begin
                    case (s_q.pix_cnt)
                        2'd0: begin
                            s_d.red     = w_data;
                            s_d.pix_cnt = 2'd1;
                        end
                        2'd1: begin
                            s_d.green   = w_data;
                            s_d.pix_cnt = 2'd2;
                        end
                        default: begin
                            s_d.pix_cnt = 2'd0;
                            if (w_pix_ok) begin
                                s_d.axis_valid = 1'b1;
                                s_d.axis_data  = {s_q.red, s_q.green, w_data};
                                s_d.axis_user  = s_q.frame_start;
                                s_d.axis_last  = (s_q.x >= w_col_end);
                            end else begin
                                s_d.overflow = 1'b1;
                            end
                            s_d.frame_start = 1'b0;
                            if (s_q.x >= w_col_end) begin
                                s_d.x = s_q.col_start;
                                if (s_q.y >= w_page_end) begin
                                    s_d.y           = s_q.page_start;
                                    s_d.frame_start = 1'b1;
                                end else begin
                                    s_d.y = s_q.y + 16'd1;
                                end
                            end else begin
                                s_d.x = s_q.x + 16'd1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end

        if (w_rd) begin
            s_d.oe    = 1'b1;
            s_d.rdata = 8'h00;
            if (s_q.route == CMD_RDID) begin
                case (s_q.rd_idx)
                    2'd0:    s_d.rdata = ID_BYTE1;
                    2'd1:    s_d.rdata = ID_BYTE2;
                    2'd2:    s_d.rdata = ID_BYTE3;
                    default: s_d.rdata = 8'h00;
                endcase
                if (s_q.rd_idx != 2'd3) s_d.rd_idx = s_q.rd_idx + 2'd1;
            end else if (s_q.route == CMD_RDTE) begin
                s_d.rdata = s_q.te ? TE_STATUS_HIGH : TE_STATUS_LOW;
            end
        end

        if (w_swreset) begin
            s_d          = state_reset(16'(COL_END_DEFAULT), 16'(PAGE_END_DEFAULT));
            s_d.overflow = s_q.overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            s_q <= state_reset(16'(COL_END_DEFAULT), 16'(PAGE_END_DEFAULT));
        end else begin
            s_q <= s_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst || w_swreset) begin
            te_cnt_q <= '0;
        end else if (te_cnt_q == TE_W'(TE_PERIOD - 1)) begin
            te_cnt_q <= '0;
        end else begin
            te_cnt_q <= te_cnt_q + 1'b1;
        end
    end

    assign o_data           = s_q.rdata;
    assign o_data_oe        = s_q.oe;
    assign o_tearing_effect = s_q.te;
    assign o_axis_valid     = s_q.axis_valid;
    assign o_axis_data      = s_q.axis_data;
    assign o_axis_last      = s_q.axis_last;
    assign o_axis_user      = s_q.axis_user;
    assign o_cmd            = s_q.cmd;
    assign o_te_enable      = s_q.te_en;
    assign o_overflow       = s_q.overflow;

endmodule
`default_nettype wire

// File: doc/tft_8080_responder.md
Name: tft_8080_responder

Overview:
- Synthesizable panel-side model of the 8-bit 8080-style TFT bus driven by axi_pmod_tft: the responder end of that bus.
- Decodes command/parameter writes, answers register reads, and generates the tearing-effect (TE) strobe.
- Repacks memory-write pixel bytes into a 24-bit AXI-Stream for frame checking.
- Used in simulation benches and for FPGA loopback of the TFT controller.

Parameters:
- TE_PERIOD, 800, clk cycles per TE period.
- TE_HIGH, 400, clk cycles TE is high within each period (must be < TE_PERIOD).
- ID_BYTE1 / ID_BYTE2 / ID_BYTE3, 8'h01 / 8'h93 / 8'h41, bytes returned by the Read ID command 0x04.
- COL_END_DEFAULT, 239, column end after reset.
- PAGE_END_DEFAULT, 319, page end after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_reset_n  in  1  panel reset pin; low acts exactly like rst
- i_cs_n  in  1  chip select, active low
- i_rs  in  1  register/data select: 0 = command, 1 = parameter/data
- i_wr_n  in  1  write strobe, active low
- i_rd_n  in  1  read strobe, active low
- i_data  in  8  bus data from controller
- o_data  out  8  bus read data
- o_data_oe  out  1  drive enable for o_data
- o_tearing_effect  out  1  TE pin
- o_axis_valid  out  1  pixel valid
- i_axis_ready  in  1  pixel ready
- o_axis_data  out  24  pixel {R,G,B}
- o_axis_last  out  1  last pixel of line
- o_axis_user  out  1  first pixel of frame
- o_cmd  out  8  last command byte
- o_te_enable  out  1  TE output enabled
- o_overflow  out  1  sticky: a pixel was dropped

Behaviour:
- Reset (rst or synchronized i_reset_n low): all outputs 0.
  - Window restored to col 0..COL_END_DEFAULT, page 0..PAGE_END_DEFAULT.
  - Parameter and pixel byte counters cleared; TE disabled; TE counter 0.
  - An AXIS transfer in progress is abandoned.
- Input sync:
  - i_cs_n, i_rs, i_wr_n, i_rd_n, i_reset_n each pass through a 2-FF synchronizer.
  - i_data is sampled together with the synchronized strobes, one register stage.
- Write event: rising edge of synchronized wr_n while synchronized cs_n is low. The byte is committed 3 clk after the external wr_n rising edge.
  - rs=0: command. Sets o_cmd, clears the parameter counter and the partial-pixel byte counter.
  - rs=1: parameter. Routed by o_cmd.
- Commands:
  - 0x00 NOP.
  - 0x01 software reset: same state as rst, except o_overflow is kept.
  - 0x34 TE off; 0x35 TE on; a parameter byte after 0x35 is ignored.
  - 0x2A column set: 4 params, MSB first = col_start[15:8], col_start[7:0], col_end[15:8], col_end[7:0].
  - 0x2B page set: same format as 0x2A, for page_start/page_end.
  - 0x2C memory write: x=col_start, y=page_start, frame_start=1.
  - 0x04 read ID; 0x0E read TE status.
  - Unknown command: accepted into o_cmd; its parameters are ignored.
  - Parameters beyond the command's count are ignored.
- Window rule: if end < start, the effective end equals start.
- Memory write data:
  - Bytes are packed R, G, B.
  - On the 3rd byte the pixel is loaded into the output register: o_axis_user=frame_start, o_axis_last=(x==col_end).
  - frame_start is then cleared.
  - x increments; at col_end, x returns to col_start and y increments.
  - At (col_end, page_end), x and y wrap to the starts and frame_start is set again.
  - If o_axis_valid=1 and !i_axis_ready when a pixel completes: the pixel is dropped, o_overflow is set (sticky until reset), and x/y still advance.
  - AXIS transfer when valid&&ready; valid drops the next cycle unless a new pixel loads in the same cycle.
- Read:
  - On the falling edge of synchronized rd_n with cs_n low, o_data_oe=1 and o_data is loaded.
  - o_data_oe stays 1 while rd_n and cs_n are low and falls on the cycle the synchronized rd_n goes high.
  - 0x04: successive reads return ID_BYTE1, ID_BYTE2, ID_BYTE3, then 0x00.
  - 0x0E: returns 8'h80 if o_tearing_effect is high, else 8'h00.
  - All other commands return 0x00.
- Simultaneous wr_n and rd_n low: the write is processed and the read is ignored (o_data_oe stays 0).
- TE generator:
  - The counter runs always, 0..TE_PERIOD-1, then wraps.
  - o_tearing_effect = o_te_enable && (count < TE_HIGH), registered.
- Bus activity with cs_n high is fully ignored.

Decomposition:
- Package tft_8080_pkg holds command code constants (CMD_NOP, CMD_SWRESET, CMD_RDID, CMD_RDTE, CMD_TEOFF, CMD_TEON, CMD_CASET, CMD_PASET, CMD_RAMWR) and the TE status byte values.
- One sub-module, tft_8080_bus_sync: synchronizers plus wr/rd edge detect; outputs one-cycle write_strobe/read_strobe, rs and data.
- Command decode, window counters, AXIS output and TE generator stay in the top module.

Test Plan:
- Reset, then TE on (0x35) -> o_tearing_effect high for 400 clk, low for 400 clk, repeating. After 0x34 -> stays 0.
- 0x2A params 00,02,00,04; 0x2B params 00,00,00,01; 0x2C; 9 pixels of bytes (n,n,n), i_axis_ready=1 -> data 0x000000, 0x010101, ...; user on pixels 0 and 6; last on pixels 2, 5, 8.
- Same window with i_axis_ready=0 for two pixels -> first pixel held, second dropped, o_overflow=1, subsequent pixel still reaches coordinate (4,1) with last=1.
- Command 0x04, four reads -> 0x01, 0x93, 0x41, 0x00; o_data_oe tracks rd_n low. 0x0E read while TE high -> 0x80; while TE low -> 0x00.
- 0x2C, two bytes, then command 0x00, then 3 bytes -> one pixel emitted, built only from the last 3 bytes. 0x01 mid-frame -> window defaults restored, TE off, o_overflow retained.
- wr_n and rd_n low together with cs_n low -> write committed, o_data_oe stays 0. Same strobes with cs_n high -> no change.
